// File: rtl/wb_gpio_irq.sv
`default_nettype none
// ============================================================================
//  Module   : wb_gpio_irq
//  Purpose  : Wishbone classic GPIO slave with per-pin direction, input
//             synchroniser, rise/fall edge interrupts (W1C status) and
//             atomic set/clear aliases for the output register.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_gpio_irq #(
  parameter int               WIDTH       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq_o
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);

  localparam logic [2:0] ADDR_IN      = 3'd0;
  localparam logic [2:0] ADDR_OUT     = 3'd1;
  localparam logic [2:0] ADDR_DIR     = 3'd2;
  localparam logic [2:0] ADDR_RISE_EN = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN = 3'd4;
  localparam logic [2:0] ADDR_STATUS  = 3'd5;
  localparam logic [2:0] ADDR_OUT_SET = 3'd6;
  localparam logic [2:0] ADDR_OUT_CLR = 3'd7;

  logic [WIDTH-1:0]                  data_out;
  logic [WIDTH-1:0]                  dir;
  logic [WIDTH-1:0]                  rise_en;
  logic [WIDTH-1:0]                  fall_en;
  logic [WIDTH-1:0]                  status;
  logic [WIDTH-1:0]                  prev;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain;
  logic [CNT_W-1:0]                  settle_cnt;

  logic [2:0]       addr;
  logic             access;
  logic             wr;
  logic [31:0]      sel_mask32;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wbits;
  logic [WIDTH-1:0] sync_val;
  logic             settled;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] status_next;
  logic [WIDTH-1:0] rd_val;
  logic [31:0]      rd_word;
  logic             unused_bus_bits;

  // A new access is accepted only when ack is low, so strobes held high
  // are acknowledged on alternate cycles.
  assign addr       = wb_adr_i[4:2];
  assign access     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr         = access & wb_we_i;
  assign sel_mask32 = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                       {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wmask      = sel_mask32[WIDTH-1:0];
  // Write data already qualified by the byte enables; bits >= WIDTH drop out.
  assign wbits      = wb_dat_i[WIDTH-1:0] & wmask;

  // Only address bits [4:2] and the low WIDTH data bits are meaningful.
  assign unused_bus_bits = ^{wb_adr_i, wb_dat_i, sel_mask32};

  assign sync_val = sync_chain[SYNC_STAGES-1];
  assign settled  = (settle_cnt == '0);
  assign rise     = sync_val & ~prev & rise_en & {WIDTH{settled}};
  assign fall     = ~sync_val & prev & fall_en & {WIDTH{settled}};
  assign w1c_mask = (wr && addr == ADDR_STATUS) ? wbits : '0;
  // Edges are OR-ed in after the clear so a same-cycle edge keeps its bit.
  assign status_next = (status & ~w1c_mask) | rise | fall;

  assign gpio_o  = data_out;
  assign gpio_oe = dir;

  // Read multiplexer; write-only aliases and unused addresses read zero.
  always_comb begin
    rd_val  = '0;
    rd_word = '0;
    case (addr)
      ADDR_IN:      rd_val = sync_val;
      ADDR_OUT:     rd_val = data_out;
      ADDR_DIR:     rd_val = dir;
      ADDR_RISE_EN: rd_val = rise_en;
      ADDR_FALL_EN: rd_val = fall_en;
      ADDR_STATUS:  rd_val = status;
      default:      rd_val = '0;
    endcase
    rd_word[WIDTH-1:0] = rd_val;
  end

  // Pad synchroniser, edge history and post-reset settle countdown.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_chain <= '0;
      prev       <= '0;
      settle_cnt <= CNT_W'(SYNC_STAGES + 1);
    end else begin
      sync_chain[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_chain[i] <= sync_chain[i-1];
      end
      prev <= sync_val;
      if (settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
    end
  end

  // Bus handshake, register writes, interrupt status and IRQ output.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      data_out <= OUT_RESET;
      dir      <= DIR_RESET;
      rise_en  <= '0;
      fall_en  <= '0;
      status   <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      irq_o    <= 1'b0;
    end else begin
      wb_ack_o <= access;
      wb_dat_o <= (access && !wb_we_i) ? rd_word : 32'd0;
      status   <= status_next;
      irq_o    <= |status_next;
      if (wr) begin
        case (addr)
          ADDR_OUT:     data_out <= (data_out & ~wmask) | wbits;
          ADDR_DIR:     dir      <= (dir & ~wmask) | wbits;
          ADDR_RISE_EN: rise_en  <= (rise_en & ~wmask) | wbits;
          ADDR_FALL_EN: fall_en  <= (fall_en & ~wmask) | wbits;
          ADDR_OUT_SET: data_out <= data_out | wbits;
          ADDR_OUT_CLR: data_out <= data_out & ~wbits;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_gpio_irq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_gpio_irq
//  Purpose  : Directed self-checking bench for wb_gpio_irq (16-bit/2-stage
//             and 32-bit/3-stage instances sharing one Wishbone bus).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_gpio_irq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        we  = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;

  logic [31:0] dat16, dat32;
  logic        ack16, ack32, irq16, irq32;
  logic [15:0] gpio_i16 = '0, gpio_o16, oe16;
  logic [31:0] gpio_i32 = '0, gpio_o32, oe32;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  wb_gpio_irq #(.WIDTH(16), .SYNC_STAGES(2),
                .OUT_RESET(16'h00A5), .DIR_RESET(16'h00FF)) dut16 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_dat_o(dat16), .wb_ack_o(ack16), .gpio_i(gpio_i16),
    .gpio_o(gpio_o16), .gpio_oe(oe16), .irq_o(irq16));

  wb_gpio_irq #(.WIDTH(32), .SYNC_STAGES(3),
                .OUT_RESET(32'h8000_0001), .DIR_RESET(32'hF000_000F)) dut32 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_dat_o(dat32), .wb_ack_o(ack32), .gpio_i(gpio_i32),
    .gpio_o(gpio_o32), .gpio_oe(oe32), .irq_o(irq32));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One Wishbone access with stb held for two edges: ack must rise on the
  // first and fall on the second. Read expectations go through the queue.
  task automatic xfer(input bit big, input bit w, input logic [2:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    logic [31:0] e;
    if (!w) exp_q.push_back(d);
    adr = {27'd0, a, 2'b00};
    dat = w ? d : 32'd0;
    sel = s;
    we  = w;
    cyc = 1'b1;
    stb = 1'b1;
    tick();
    chk($sformatf("ack_rise_a%0d", a), big ? ack32 : ack16, 32'd1);
    if (!w) begin
      e = exp_q.pop_front();
      chk($sformatf("rdata_a%0d", a), big ? dat32 : dat16, e);
    end
    tick();
    chk($sformatf("ack_fall_a%0d", a), big ? ack32 : ack16, 32'd0);
    chk($sformatf("dat_idle_a%0d", a), big ? dat32 : dat16, 32'd0);
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  initial begin
    // ---- Reset values ----
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_gpio_o16", gpio_o16, 32'h00A5);
    chk("rst_oe16",     oe16,     32'h00FF);
    chk("rst_irq16",    irq16,    32'd0);
    chk("rst_ack16",    ack16,    32'd0);
    chk("rst_dat16",    dat16,    32'd0);
    chk("rst_gpio_o32", gpio_o32, 32'h8000_0001);
    chk("rst_oe32",     oe32,     32'hF000_000F);

    // ---- All eight addresses after reset (pads low) ----
    xfer(0, 0, 3'd0, 32'h0000_0000, 4'hF);
    xfer(0, 0, 3'd1, 32'h0000_00A5, 4'hF);
    xfer(0, 0, 3'd2, 32'h0000_00FF, 4'hF);
    for (int i = 3; i < 8; i++) xfer(0, 0, 3'(i), 32'd0, 4'hF);

    // ---- Output register, set/clear aliases, byte enables ----
    xfer(0, 1, 3'd1, 32'h0000_1234, 4'hF);
    xfer(0, 1, 3'd6, 32'h0000_00C0, 4'hF);
    xfer(0, 1, 3'd7, 32'h0000_0204, 4'hF);
    chk("out_setclr", gpio_o16, 32'h10F0);
    xfer(0, 1, 3'd1, 32'h0000_FFFF, 4'b0001);
    chk("out_sel0", gpio_o16, 32'h10FF);
    xfer(0, 1, 3'd6, 32'h0000_FF00, 4'b0001);
    chk("set_sel_gated", gpio_o16, 32'h10FF);
    xfer(0, 0, 3'd1, 32'h0000_10FF, 4'hF);

    // ---- Rise on pin 0, fall on pin 1, W1C sequencing ----
    gpio_i16 = 16'h0002;
    repeat (5) tick();
    xfer(0, 1, 3'd3, 32'h0000_0001, 4'hF);
    xfer(0, 1, 3'd4, 32'h0000_0002, 4'hF);
    xfer(0, 0, 3'd5, 32'h0000_0000, 4'hF);
    gpio_i16 = 16'h0001;
    repeat (2) tick();
    chk("irq_not_yet", irq16, 32'd0);
    repeat (2) tick();
    chk("irq_edge", irq16, 32'd1);
    xfer(0, 0, 3'd5, 32'h0000_0003, 4'hF);
    xfer(0, 0, 3'd0, 32'h0000_0001, 4'hF);
    xfer(0, 1, 3'd5, 32'h0000_0001, 4'hF);
    xfer(0, 0, 3'd5, 32'h0000_0002, 4'hF);
    chk("irq_partial_clr", irq16, 32'd1);
    xfer(0, 1, 3'd5, 32'h0000_0002, 4'b0001);
    chk("irq_all_clr", irq16, 32'd0);
    xfer(0, 0, 3'd5, 32'h0000_0000, 4'hF);

    // ---- Edge on pin 3 lands on the same edge as its W1C ----
    xfer(0, 1, 3'd3, 32'h0000_0008, 4'hF);
    gpio_i16 = 16'h0009;
    repeat (2) tick();
    xfer(0, 1, 3'd5, 32'h0000_0008, 4'hF);
    chk("edge_beats_w1c_irq", irq16, 32'd1);
    xfer(0, 0, 3'd5, 32'h0000_0008, 4'hF);
    xfer(0, 1, 3'd5, 32'h0000_0008, 4'hF);
    chk("irq_after_clr3", irq16, 32'd0);

    // ---- Static-high pads through reset: settle suppresses edges ----
    gpio_i16 = 16'hFFFF;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    xfer(0, 1, 3'd3, 32'h0000_FFFF, 4'hF);
    repeat (6) tick();
    chk("settle_irq", irq16, 32'd0);
    chk("rerst_gpio_o16", gpio_o16, 32'h00A5);
    xfer(0, 0, 3'd5, 32'h0000_0000, 4'hF);
    xfer(0, 0, 3'd0, 32'h0000_FFFF, 4'hF);

    // ---- 32-bit instance: full-width data and 3-stage input latency ----
    xfer(1, 1, 3'd1, 32'hDEAD_BEEF, 4'hF);
    chk("out32_full", gpio_o32, 32'hDEAD_BEEF);
    gpio_i32 = 32'h8000_0000;
    repeat (2) tick();
    xfer(1, 0, 3'd0, 32'h0000_0000, 4'hF);
    repeat (2) tick();
    xfer(1, 0, 3'd0, 32'h8000_0000, 4'hF);
    gpio_i32 = 32'h0000_0000;
    repeat (3) tick();
    xfer(1, 0, 3'd0, 32'h0000_0000, 4'hF);

    // ---- Reset in the middle of a write: aborted, no ack ----
    adr = 32'h0000_0004;
    dat = 32'h1234_5678;
    sel = 4'hF;
    we  = 1'b1;
    cyc = 1'b1;
    stb = 1'b1;
    rst = 1'b1;
    tick();
    chk("abort_ack32", ack32, 32'd0);
    chk("abort_ack16", ack16, 32'd0);
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    rst = 1'b0;
    tick();
    chk("abort_ack32_late", ack32, 32'd0);
    chk("abort_out32", gpio_o32, 32'h8000_0001);
    chk("abort_oe32",  oe32,     32'hF000_000F);
    chk("abort_irq32", irq32,    32'd0);
    xfer(1, 0, 3'd1, 32'h8000_0001, 4'hF);
    xfer(1, 0, 3'd2, 32'hF000_000F, 4'hF);
    xfer(1, 0, 3'd3, 32'h0000_0000, 4'hF);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
